// File: rtl/arbitro_memoria_pkg.sv
// Shared types and default widths for the IF/MEM unified-memory arbiter.
package pkg_memoria;

  localparam int ANCHO_DIR_DEF        = 32;
  localparam int ANCHO_DATOS_DEF      = 32;
  localparam int LIMITE_INANICION_DEF = 4;
  localparam int ANCHO_CONT           = 4;

  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    SERV_IF  = 2'd1,
    SERV_DM  = 2'd2,
    DESCARTE = 2'd3
  } estado_arb_t;

  typedef struct packed {
    logic                         we;
    logic [ANCHO_DIR_DEF-1:0]     addr;
    logic [ANCHO_DATOS_DEF-1:0]   wdata;
    logic [ANCHO_DATOS_DEF/8-1:0] be;
  } peticion_mem_t;

endpackage

// File: rtl/arbitro_memoria_contador.sv
// Saturating count of data grants made while a fetch was waiting.
module contador_inanicion
  import pkg_memoria::*;
#(
  parameter int LIMITE_INANICION = LIMITE_INANICION_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic inc_i,
  input  logic clr_i,
  output logic sat_o
);

  localparam logic [ANCHO_CONT-1:0] LIMITE = ANCHO_CONT'(LIMITE_INANICION);

  if (LIMITE_INANICION < 1 || LIMITE_INANICION > 15) begin : g_limite_invalido
    $error("LIMITE_INANICION must be in 1..15");
  end

  logic [ANCHO_CONT-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (clr_i) begin
      cuenta_d = '0;
    end else if (inc_i && (cuenta_q != LIMITE)) begin
      cuenta_d = cuenta_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign sat_o = (cuenta_q == LIMITE);

endmodule

// File: rtl/arbitro_memoria.sv
// Arbitrates a single-port variable-latency memory between instruction fetch
// and data access, with fetch cancellation and starvation protection.
module arbitro_memoria
  import pkg_memoria::*;
#(
  parameter int ANCHO_DIR        = ANCHO_DIR_DEF,
  parameter int ANCHO_DATOS      = ANCHO_DATOS_DEF,
  parameter int LIMITE_INANICION = LIMITE_INANICION_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     if_req_i,
  input  logic [ANCHO_DIR-1:0]     if_addr_i,
  input  logic                     if_flush_i,
  output logic [ANCHO_DATOS-1:0]   if_rdata_o,
  output logic                     if_valid_o,
  input  logic                     dm_req_i,
  input  logic                     dm_we_i,
  input  logic [ANCHO_DIR-1:0]     dm_addr_i,
  input  logic [ANCHO_DATOS-1:0]   dm_wdata_i,
  input  logic [ANCHO_DATOS/8-1:0] dm_be_i,
  output logic [ANCHO_DATOS-1:0]   dm_rdata_o,
  output logic                     dm_valid_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [ANCHO_DIR-1:0]     mem_addr_o,
  output logic [ANCHO_DATOS-1:0]   mem_wdata_o,
  output logic [ANCHO_DATOS/8-1:0] mem_be_o,
  input  logic                     mem_ack_i,
  input  logic [ANCHO_DATOS-1:0]   mem_rdata_i,
  output logic                     stall_if_o,
  output logic                     stall_mem_o
);

  // The latched request uses the package struct, so widths must match it.
  if (ANCHO_DIR != ANCHO_DIR_DEF || ANCHO_DATOS != ANCHO_DATOS_DEF) begin : g_anchos_invalidos
    $error("ANCHO_DIR/ANCHO_DATOS must match pkg_memoria defaults");
  end

  estado_arb_t            estado_q, estado_d;
  peticion_mem_t          pet_q, pet_d;
  logic [ANCHO_DATOS-1:0] if_rdata_q, dm_rdata_q;
  logic                   sat;
  logic                   conceder_if, conceder_dm;
  logic                   ack_if_ok, ack_dm;

  always_comb begin
    conceder_dm = 1'b0;
    conceder_if = 1'b0;
    if (estado_q == REPOSO) begin
      if (dm_req_i && !(if_req_i && sat)) begin
        conceder_dm = 1'b1;
      end else if (if_req_i) begin
        conceder_if = 1'b1;
      end
    end
  end

  // A flush landing on the ack cycle suppresses the fetch result.
  assign ack_if_ok = !reset && (estado_q == SERV_IF) && mem_ack_i && !if_flush_i;
  assign ack_dm    = !reset && (estado_q == SERV_DM) && mem_ack_i;

  always_comb begin
    estado_d = estado_q;
    pet_d    = pet_q;
    case (estado_q)
      REPOSO: begin
        if (conceder_dm) begin
          estado_d    = SERV_DM;
          pet_d.we    = dm_we_i;
          pet_d.addr  = dm_addr_i;
          pet_d.wdata = dm_wdata_i;
          pet_d.be    = dm_be_i;
        end else if (conceder_if) begin
          estado_d    = SERV_IF;
          pet_d.we    = 1'b0;
          pet_d.addr  = if_addr_i;
          pet_d.wdata = '0;
          pet_d.be    = '1;
        end
      end
      SERV_IF: begin
        if (mem_ack_i) begin
          estado_d = REPOSO;
        end else if (if_flush_i) begin
          estado_d = DESCARTE;
        end
      end
      SERV_DM, DESCARTE: begin
        if (mem_ack_i) begin
          estado_d = REPOSO;
        end
      end
      default: estado_d = REPOSO;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q   <= REPOSO;
      pet_q      <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      estado_q <= estado_d;
      pet_q    <= pet_d;
      if (ack_if_ok) begin
        if_rdata_q <= mem_rdata_i;
      end
      if (ack_dm) begin
        dm_rdata_q <= mem_rdata_i;
      end
    end
  end

  contador_inanicion #(
    .LIMITE_INANICION(LIMITE_INANICION)
  ) u_contador (
    .clk   (clk),
    .reset (reset),
    .inc_i (conceder_dm && if_req_i),
    .clr_i (conceder_if),
    .sat_o (sat)
  );

  assign mem_req_o   = !reset && (estado_q != REPOSO);
  assign mem_we_o    = pet_q.we;
  assign mem_addr_o  = pet_q.addr;
  assign mem_wdata_o = pet_q.wdata;
  assign mem_be_o    = pet_q.be;

  assign if_valid_o  = ack_if_ok;
  assign if_rdata_o  = ack_if_ok ? mem_rdata_i : if_rdata_q;
  assign dm_valid_o  = ack_dm;
  assign dm_rdata_o  = ack_dm ? mem_rdata_i : dm_rdata_q;

  assign stall_mem_o = !reset && dm_req_i && !ack_dm;
  assign stall_if_o  = stall_mem_o || (!reset && if_req_i && !ack_if_ok);

endmodule

// File: tb/tb_arbitro_memoria.sv
// Directed bench for arbitro_memoria: stimulus pushes expectations, a monitor
// pops and compares on every valid pulse and every memory ack.
module tb_arbitro_memoria;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req_i, if_flush_i, if_valid_o;
  logic [31:0] if_addr_i, if_rdata_o;
  logic        dm_req_i, dm_we_i, dm_valid_o;
  logic [31:0] dm_addr_i, dm_wdata_i, dm_rdata_o;
  logic [3:0]  dm_be_i, mem_be_o;
  logic        mem_req_o, mem_we_o, mem_ack_i;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        stall_if_o, stall_mem_o;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } tx_t;

  tx_t         exp_mem_q[$];
  logic [31:0] exp_if_q[$];
  logic [31:0] exp_dm_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int          ack_delay;
  int          checks;
  int          errors;

  arbitro_memoria #(
    .ANCHO_DIR(32), .ANCHO_DATOS(32), .LIMITE_INANICION(2)
  ) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_rdata_o(if_rdata_o), .if_valid_o(if_valid_o),
    .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i),
    .dm_wdata_i(dm_wdata_i), .dm_be_i(dm_be_i),
    .dm_rdata_o(dm_rdata_o), .dm_valid_o(dm_valid_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_be_o(mem_be_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_if_o(stall_if_o), .stall_mem_o(stall_mem_o)
  );

  always #5 clk = ~clk;

  // Memory model: acks ack_delay cycles after mem_req_o rises.
  initial begin
    int cnt;
    cnt = 0;
    mem_ack_i = 1'b0;
    mem_rdata_i = '0;
    forever begin
      @(posedge clk);
      #2;
      if (reset || mem_ack_i || !mem_req_o) begin
        mem_ack_i = 1'b0;
        cnt = 0;
      end else if (cnt >= ack_delay) begin
        mem_ack_i = 1'b1;
        mem_rdata_i = mem_model.exists(mem_addr_o) ? mem_model[mem_addr_o] : 32'h0;
      end else begin
        cnt++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic exp_tx(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be);
    tx_t t;
    t.we = we; t.addr = addr; t.wdata = wdata; t.be = be;
    exp_mem_q.push_back(t);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic monitor();
    tx_t e;
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (if_valid_o) begin
          if (exp_if_q.size() == 0) chk("if_valid_unexpected", 32'd1, 32'd0);
          else chk("if_rdata", if_rdata_o, exp_if_q.pop_front());
          $display("IF  done rdata=%h t=%0t", if_rdata_o, $time);
        end
        if (dm_valid_o) begin
          if (exp_dm_q.size() == 0) chk("dm_valid_unexpected", 32'd1, 32'd0);
          else chk("dm_rdata", dm_rdata_o, exp_dm_q.pop_front());
          $display("DM  done rdata=%h t=%0t", dm_rdata_o, $time);
        end
        if (mem_req_o && mem_ack_i) begin
          $display("MEM ack  addr=%h we=%b be=%h t=%0t", mem_addr_o, mem_we_o, mem_be_o, $time);
          if (exp_mem_q.size() == 0) begin
            chk("mem_ack_unexpected", mem_addr_o, 32'hFFFF_FFFF);
          end else begin
            e = exp_mem_q.pop_front();
            chk("mem_addr", mem_addr_o, e.addr);
            chk("mem_we", {31'b0, mem_we_o}, {31'b0, e.we});
            chk("mem_be", {28'b0, mem_be_o}, {28'b0, e.be});
            if (e.we) chk("mem_wdata", mem_wdata_o, e.wdata);
          end
        end
      end
    end
  endtask

  // Hold both requests; advance each address after its completion.
  task automatic run_both(input logic [31:0] dbase, input logic [31:0] ibase,
                          input logic [3:0] be, input int n_if);
    int   seen_if;
    logic dv, iv;
    seen_if = 0;
    tick();
    dm_we_i = 1'b0; dm_be_i = be; dm_addr_i = dbase; if_addr_i = ibase;
    dm_req_i = 1'b1; if_req_i = 1'b1;
    for (int c = 0; c < 80; c++) begin
      sample();
      dv = dm_valid_o;
      iv = if_valid_o;
      if (iv) seen_if++;
      tick();
      if (seen_if == n_if) begin
        dm_req_i = 1'b0; if_req_i = 1'b0;
        return;
      end
      if (dv) dm_addr_i = dm_addr_i + 32'd4;
      if (iv) if_addr_i = if_addr_i + 32'd4;
    end
    chk("run_both_timeout", seen_if, n_if);
    dm_req_i = 1'b0; if_req_i = 1'b0;
  endtask

  initial begin
    checks = 0; errors = 0; ack_delay = 1;
    reset = 1'b1;
    if_req_i = 0; if_addr_i = '0; if_flush_i = 0;
    dm_req_i = 0; dm_we_i = 0; dm_addr_i = '0; dm_wdata_i = '0; dm_be_i = '0;
    mem_model[32'h100] = 32'h00500093; mem_model[32'h300] = 32'h00A00113;
    mem_model[32'h400] = 32'h11110400; mem_model[32'h404] = 32'h22220404;
    mem_model[32'h408] = 32'h33330408; mem_model[32'h40C] = 32'h4444040C;
    mem_model[32'h500] = 32'h00000513; mem_model[32'h504] = 32'h00100593;
    mem_model[32'h600] = 32'hFFFF0600; mem_model[32'h700] = 32'hEEEE0700;
    mem_model[32'h800] = 32'hCAFEF00D; mem_model[32'h904] = 32'h0BADC0DE;
    mem_model[32'h908] = 32'h0BADC0E2; mem_model[32'hA00] = 32'h00C00193;
    fork
      monitor();
    join_none

    // Reset state
    repeat (3) @(posedge clk);
    sample();
    chk("rst_mem_req", {31'b0, mem_req_o}, 0);
    chk("rst_if_valid", {31'b0, if_valid_o}, 0);
    chk("rst_dm_valid", {31'b0, dm_valid_o}, 0);
    chk("rst_stall_if", {31'b0, stall_if_o}, 0);
    chk("rst_stall_mem", {31'b0, stall_mem_o}, 0);
    chk("rst_mem_addr", mem_addr_o, 0);
    chk("rst_mem_be", {28'b0, mem_be_o}, 0);
    chk("rst_dm_rdata", dm_rdata_o, 0);
    tick(); reset = 1'b0;

    // Lone fetch, ack two cycles after mem_req_o rises
    ack_delay = 2;
    exp_if_q.push_back(32'h00500093);
    exp_tx(1'b0, 32'h100, 32'h0, 4'hF);
    tick(); if_req_i = 1; if_addr_i = 32'h100;
    sample(); chk("t1_req_c0", {31'b0, mem_req_o}, 0); chk("t1_stall_c0", {31'b0, stall_if_o}, 1);
    tick(); sample();
    chk("t1_req_c1", {31'b0, mem_req_o}, 1); chk("t1_addr_c1", mem_addr_o, 32'h100);
    chk("t1_stall_c1", {31'b0, stall_if_o}, 1);
    tick(); sample(); chk("t1_stall_c2", {31'b0, stall_if_o}, 1);
    tick(); sample(); chk("t1_valid_c3", {31'b0, if_valid_o}, 1);
    chk("t1_stall_c3", {31'b0, stall_if_o}, 0);
    tick(); if_req_i = 0;
    sample(); chk("t1_req_c4", {31'b0, mem_req_o}, 0); chk("t1_rdata_hold", if_rdata_o, 32'h00500093);

    // Simultaneous requests: data store first, bubble, then fetch
    ack_delay = 1;
    exp_tx(1'b1, 32'h200, 32'hDEADBEEF, 4'hF);
    exp_dm_q.push_back(32'h0);
    exp_tx(1'b0, 32'h300, 32'h0, 4'hF);
    exp_if_q.push_back(32'h00A00113);
    tick(); if_req_i = 1; if_addr_i = 32'h300;
    dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h200; dm_wdata_i = 32'hDEADBEEF; dm_be_i = 4'hF;
    sample(); chk("t2_stall_if_c0", {31'b0, stall_if_o}, 1); chk("t2_stall_mem_c0", {31'b0, stall_mem_o}, 1);
    tick(); sample();
    chk("t2_we_c1", {31'b0, mem_we_o}, 1); chk("t2_wdata_c1", mem_wdata_o, 32'hDEADBEEF);
    chk("t2_stall_if_c1", {31'b0, stall_if_o}, 1);
    tick(); sample();
    chk("t2_dm_valid_c2", {31'b0, dm_valid_o}, 1); chk("t2_stall_mem_c2", {31'b0, stall_mem_o}, 0);
    chk("t2_stall_if_c2", {31'b0, stall_if_o}, 1);
    tick(); dm_req_i = 0;
    sample(); chk("t2_bubble_c3", {31'b0, mem_req_o}, 0); chk("t2_stall_if_c3", {31'b0, stall_if_o}, 1);
    tick(); sample();
    chk("t2_if_addr_c4", mem_addr_o, 32'h300); chk("t2_if_we_c4", {31'b0, mem_we_o}, 0);
    chk("t2_stall_if_c4", {31'b0, stall_if_o}, 1);
    tick(); sample(); chk("t2_if_valid_c5", {31'b0, if_valid_o}, 1); chk("t2_stall_if_c5", {31'b0, stall_if_o}, 0);
    tick(); if_req_i = 0;

    // Starvation with limit 2: DM, DM, IF, DM, DM, IF
    ack_delay = 0;
    exp_tx(1'b0, 32'h400, 32'h0, 4'h3); exp_tx(1'b0, 32'h404, 32'h0, 4'h3);
    exp_tx(1'b0, 32'h500, 32'h0, 4'hF); exp_tx(1'b0, 32'h408, 32'h0, 4'h3);
    exp_tx(1'b0, 32'h40C, 32'h0, 4'h3); exp_tx(1'b0, 32'h504, 32'h0, 4'hF);
    exp_dm_q.push_back(32'h11110400); exp_dm_q.push_back(32'h22220404);
    exp_dm_q.push_back(32'h33330408); exp_dm_q.push_back(32'h4444040C);
    exp_if_q.push_back(32'h00000513); exp_if_q.push_back(32'h00100593);
    run_both(32'h400, 32'h500, 4'h3, 2);
    sample(); sample();

    // Flush before ack: fetch discarded, mem_req_o held through ack
    ack_delay = 2;
    exp_tx(1'b0, 32'h600, 32'h0, 4'hF);
    tick(); if_req_i = 1; if_addr_i = 32'h600;
    tick(); if_flush_i = 1;
    sample(); chk("t4_req_c1", {31'b0, mem_req_o}, 1);
    tick(); if_flush_i = 0; if_req_i = 0;
    sample(); chk("t4_req_desc", {31'b0, mem_req_o}, 1); chk("t4_stall_if", {31'b0, stall_if_o}, 0);
    tick(); if_flush_i = 1;
    sample(); chk("t4_req_ack", {31'b0, mem_req_o}, 1); chk("t4_no_valid", {31'b0, if_valid_o}, 0);
    tick(); if_flush_i = 0;
    sample(); chk("t4_req_done", {31'b0, mem_req_o}, 0);

    // Flush on the ack cycle: no valid, straight back to REPOSO
    ack_delay = 1;
    exp_tx(1'b0, 32'h700, 32'h0, 4'hF);
    tick(); if_req_i = 1; if_addr_i = 32'h700;
    tick();
    tick(); if_flush_i = 1;
    sample(); chk("t5_no_valid", {31'b0, if_valid_o}, 0);
    tick(); if_flush_i = 0; if_req_i = 0;
    sample(); chk("t5_req_after", {31'b0, mem_req_o}, 0);

    // Flush during a load has no effect
    exp_tx(1'b0, 32'h800, 32'h0, 4'hF);
    exp_dm_q.push_back(32'hCAFEF00D);
    tick(); dm_req_i = 1; dm_we_i = 0; dm_addr_i = 32'h800; dm_be_i = 4'hF;
    tick(); if_flush_i = 1;
    tick();
    sample(); chk("t5b_dm_valid", {31'b0, dm_valid_o}, 1); chk("t5b_stall_mem", {31'b0, stall_mem_o}, 0);
    tick(); dm_req_i = 0; if_flush_i = 0;
    sample(); chk("t5b_rdata_hold", dm_rdata_o, 32'hCAFEF00D);

    // Reset in the middle of a store; counter must restart at 0
    ack_delay = 5;
    tick(); dm_req_i = 1; dm_we_i = 1; dm_addr_i = 32'h900; dm_wdata_i = 32'h12345678;
    if_req_i = 1; if_addr_i = 32'hA00;
    tick(); sample(); chk("t6_req_busy", {31'b0, mem_req_o}, 1);
    tick(); reset = 1; dm_req_i = 0; if_req_i = 0;
    tick(); reset = 0;
    sample();
    chk("t6_mem_req", {31'b0, mem_req_o}, 0); chk("t6_mem_we", {31'b0, mem_we_o}, 0);
    chk("t6_mem_addr", mem_addr_o, 0); chk("t6_mem_wdata", mem_wdata_o, 0);
    chk("t6_dm_rdata", dm_rdata_o, 0); chk("t6_if_rdata", if_rdata_o, 0);
    chk("t6_stall_mem", {31'b0, stall_mem_o}, 0);
    ack_delay = 1;
    exp_tx(1'b0, 32'h904, 32'h0, 4'hF); exp_tx(1'b0, 32'h908, 32'h0, 4'hF);
    exp_tx(1'b0, 32'hA00, 32'h0, 4'hF);
    exp_dm_q.push_back(32'h0BADC0DE); exp_dm_q.push_back(32'h0BADC0E2);
    exp_if_q.push_back(32'h00C00193);
    run_both(32'h904, 32'hA00, 4'hF, 1);

    repeat (4) sample();
    chk("end_mem_q_empty", exp_mem_q.size(), 0);
    chk("end_if_q_empty", exp_if_q.size(), 0);
    chk("end_dm_q_empty", exp_dm_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
